// File: rtl/lbist_pkg.sv
// Shared types and helpers for the response compactor/comparator slice.
// Holds the session FSM state encoding and the pattern-index width helper.
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width needed to hold a pattern index 0..len-1, never less than one bit
    function automatic int idx_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/resp_cmp_lane.sv
// Single-channel comparator: flags a mismatch when any unmasked bit of the
// observed response differs from the golden response.
module resp_cmp_lane #(
    parameter int BITS = 2
) (
    input  logic [BITS-1:0] obs,
    input  logic [BITS-1:0] gold,
    input  logic [BITS-1:0] mask,
    output logic            mismatch
);

    // A set mask bit removes that bit position from the comparison
    always_comb begin
        mismatch = |((obs ^ gold) & ~mask);
    end

endmodule

// File: rtl/resp_cmp.sv
// Multi-channel response comparator with per-session error statistics.
// A session starts on 'start', accepts LEN valid patterns, then reports done.
// Optional build macro RESP_CMP_MASK_EN adds input M to exclude bits from
// comparison; without it every bit is compared and no M port exists.
module resp_cmp
    import lbist_pkg::*;
#(
    parameter int BITS     = 2,
    parameter int CHANNELS = 4,
    parameter int LEN      = 16,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     valid,
    input  logic [CHANNELS*BITS-1:0] A,
    input  logic [CHANNELS*BITS-1:0] B,
    output logic                     res,
    output logic [CHANNELS-1:0]      chan_fail,
    output logic                     fail,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [idx_w(LEN)-1:0]    first_idx,
    output logic                     busy,
    output logic                     done
`ifdef RESP_CMP_MASK_EN
    ,
    input  logic [CHANNELS*BITS-1:0] M
`endif
);

    localparam int              IW      = idx_w(LEN);
    localparam logic [IW-1:0]   LAST    = IW'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [CHANNELS*BITS-1:0]   mask_bits;
    logic [CHANNELS-1:0]        chan_mis;
    logic                       any_mis;

`ifdef RESP_CMP_MASK_EN
    assign mask_bits = M;
`else
    assign mask_bits = '0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        resp_cmp_lane #(
            .BITS (BITS)
        ) u_lane (
            .obs      (A[c*BITS +: BITS]),
            .gold     (B[c*BITS +: BITS]),
            .mask     (mask_bits[c*BITS +: BITS]),
            .mismatch (chan_mis[c])
        );
    end

    assign any_mis = |chan_mis;
    assign fail    = |chan_fail;

    // Session FSM with all status outputs registered; a zero error count
    // doubles as "no mismatch seen yet" since the counter saturates, never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res       <= 1'b0;
            chan_fail <= '0;
            err_cnt   <= '0;
            first_idx <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    res <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        chan_fail <= '0;
                        err_cnt   <= '0;
                        first_idx <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    res <= valid & any_mis;
                    if (valid) begin
                        if (any_mis) begin
                            chan_fail <= chan_fail | chan_mis;
                            if (err_cnt != CNT_MAX) begin
                                err_cnt <= err_cnt + CNT_W'(1);
                            end
                            if (err_cnt == '0) begin
                                first_idx <= idx;
                            end
                        end
                        idx <= idx + IW'(1);
                        if (idx == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    res   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resp_cmp.sv
// Testbench for resp_cmp (BITS=2, CHANNELS=4, LEN=8). A second instance with
// a 2-bit error counter exercises saturation. Optional RESP_CMP_MASK_EN build
// connects the mask input.
module tb_resp_cmp;

    localparam int BITS     = 2;
    localparam int CHANNELS = 4;
    localparam int LEN      = 8;
    localparam int W        = CHANNELS * BITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
`ifdef RESP_CMP_MASK_EN
    logic [W-1:0] M;
`endif

    logic         res,  res2;
    logic [3:0]   chf,  chf2;
    logic         fail, fail2;
    logic [3:0]   err;
    logic [1:0]   err2;
    logic [2:0]   fi,   fi2;
    logic         busy, busy2;
    logic         done, done2;

    int checksTotal  = 0;
    int checksPassed = 0;

    resp_cmp #(.BITS(BITS), .CHANNELS(CHANNELS), .LEN(LEN), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .A(A), .B(B),
        .res(res), .chan_fail(chf), .fail(fail), .err_cnt(err),
        .first_idx(fi), .busy(busy), .done(done)
`ifdef RESP_CMP_MASK_EN
        , .M(M)
`endif
    );

    resp_cmp #(.BITS(BITS), .CHANNELS(CHANNELS), .LEN(LEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .A(A), .B(B),
        .res(res2), .chan_fail(chf2), .fail(fail2), .err_cnt(err2),
        .first_idx(fi2), .busy(busy2), .done(done2)
`ifdef RESP_CMP_MASK_EN
        , .M(M)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: session flag, accepted-pattern count, list of
    // mismatching pattern indices, sticky channel flags, last-cycle result
    bit         mSession = 0;
    int         mCount   = 0;
    int         mMis[$];
    logic [3:0] mChf     = '0;
    logic       mRes     = 1'b0;

    typedef struct {
        bit         rst, start, valid;
        logic [7:0] a, b;
        logic       res;
        logic [3:0] chf;
        int         err, err2, fi;
        logic       busy, done;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit r, s, v, input logic [7:0] a, b,
                          input logic eres, input logic [3:0] echf,
                          input int eerr, eerr2, efi, input logic ebusy, edone);
        vec_t t;
        t.rst = r; t.start = s; t.valid = v; t.a = a; t.b = b;
        t.res = eres; t.chf = echf; t.err = eerr; t.err2 = eerr2; t.fi = efi;
        t.busy = ebusy; t.done = edone;
        vecs.push_back(t);
    endtask

    function automatic int satErr(input int w);
        int mx = (1 << w) - 1;
        return (mMis.size() > mx) ? mx : mMis.size();
    endfunction

    task automatic modelStep(input bit r, s, v, input logic [7:0] a, b, m);
        logic [3:0] cm;
        if (r) begin
            mSession = 0; mCount = 0; mMis.delete(); mChf = '0; mRes = 1'b0;
        end else if (s && (!mSession || mCount == LEN)) begin
            mSession = 1; mCount = 0; mMis.delete(); mChf = '0; mRes = 1'b0;
        end else if (mSession && mCount < LEN && v) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cm[c] = (((a >> (2*c)) ^ (b >> (2*c))) & ~(m >> (2*c)) & 8'h03) != 8'h00;
            end
            mRes = |cm;
            if (mRes) mMis.push_back(mCount);
            mChf = mChf | cm;
            mCount++;
        end else begin
            mRes = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, take the edge, then advance the model
    task automatic applyStimulus(input bit r, s, v, input logic [7:0] a, b, m);
        logic [7:0] effm;
        rst = r; start = s; valid = v; A = a; B = b;
`ifdef RESP_CMP_MASK_EN
        M = m;
        effm = m;
`else
        effm = m & 8'h00;
`endif
        @(posedge clk);
        #1;
        modelStep(r, s, v, a, b, effm);
    endtask

    task automatic checkOutput(input string nm, input int act, input int exp);
        checksTotal++;
        if (act == exp) checksPassed++;
        else $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic checkModel(input string tag);
        int efi;
        efi = (mMis.size() > 0) ? mMis[0] : 0;
        checkOutput({tag, " res"},       int'(res),  int'(mRes));
        checkOutput({tag, " chan_fail"}, int'(chf),  int'(mChf));
        checkOutput({tag, " fail"},      int'(fail), int'(|mChf));
        checkOutput({tag, " err_cnt"},   int'(err),  satErr(4));
        checkOutput({tag, " first_idx"}, int'(fi),   efi);
        checkOutput({tag, " busy"},      int'(busy), int'(mSession && mCount < LEN));
        checkOutput({tag, " done"},      int'(done), int'(mSession && mCount == LEN));
        checkOutput({tag, " err_cnt2"},  int'(err2), satErr(2));
        checkOutput({tag, " res2"},      int'(res2), int'(mRes));
        checkOutput({tag, " chf2"},      int'(chf2), int'(mChf));
        checkOutput({tag, " fail2"},     int'(fail2), int'(|mChf));
        checkOutput({tag, " fi2"},       int'(fi2),  efi);
        checkOutput({tag, " busy2"},     int'(busy2), int'(mSession && mCount < LEN));
        checkOutput({tag, " done2"},     int'(done2), int'(mSession && mCount == LEN));
    endtask

    initial begin
        logic [7:0] a, b, m, flip;
        bit r, s, v;

        rst = 1'b1; start = 1'b0; valid = 1'b0; A = '0; B = '0;
`ifdef RESP_CMP_MASK_EN
        M = '0;
`endif

        // Directed table: reset, one session with pattern 3 flipped on channel 2
        addVec(1, 0, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0, 1, 0);
        for (int p = 0; p < 8; p++) begin
            a = 8'(p * 37 + 5);
            b = (p == 3) ? (a ^ 8'h10) : a;
            addVec(0, 0, 1, a, b, p == 3, (p >= 3) ? 4'b0100 : 4'h0,
                   (p >= 3) ? 1 : 0, (p >= 3) ? 1 : 0, (p >= 3) ? 3 : 0, p < 7, p == 7);
        end
        // valid while DONE is ignored
        addVec(0, 0, 1, 8'hFF, 8'h00, 0, 4'b0100, 1, 1, 3, 0, 1);
        // start in DONE clears everything
        addVec(0, 1, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0, 1, 0);
        // all-matching session with a start pulse mid-run that must be ignored
        for (int p = 0; p < 8; p++) begin
            a = 8'(p * 91 + 17);
            addVec(0, p == 4, 1, a, a, 0, 4'h0, 0, 0, 0, p < 7, p == 7);
        end
        addVec(0, 1, 0, 8'h00, 8'h00, 0, 4'h0, 0, 0, 0, 1, 0);
        // every pattern mismatches; pattern 0 on channel 0 only, the rest on all
        for (int p = 0; p < 8; p++) begin
            a = 8'(p * 53 + 9);
            b = (p == 0) ? (a ^ 8'h03) : ~a;
            addVec(0, 0, 1, a, b, 1, (p == 0) ? 4'b0001 : 4'hF,
                   p + 1, (p + 1 > 3) ? 3 : p + 1, 0, p < 7, p == 7);
        end
        addVec(0, 0, 0, 8'h00, 8'h00, 0, 4'hF, 8, 3, 0, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].a, vecs[i].b, 8'h00);
            checkOutput($sformatf("vec%0d res", i),       int'(res),  int'(vecs[i].res));
            checkOutput($sformatf("vec%0d chan_fail", i), int'(chf),  int'(vecs[i].chf));
            checkOutput($sformatf("vec%0d fail", i),      int'(fail), int'(|vecs[i].chf));
            checkOutput($sformatf("vec%0d err_cnt", i),   int'(err),  vecs[i].err);
            checkOutput($sformatf("vec%0d err_cnt2", i),  int'(err2), vecs[i].err2);
            checkOutput($sformatf("vec%0d first_idx", i), int'(fi),   vecs[i].fi);
            checkOutput($sformatf("vec%0d busy", i),      int'(busy), int'(vecs[i].busy));
            checkOutput($sformatf("vec%0d done", i),      int'(done), int'(vecs[i].done));
        end

        // Reset mid-session (with start also high) returns to idle
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        for (int p = 0; p < 5; p++) applyStimulus(0, 0, 1, 8'(p), ~8'(p), 8'h00);
        checkOutput("mid err_cnt", int'(err), 5);
        applyStimulus(1, 1, 1, 8'h00, 8'hFF, 8'h00);
        checkOutput("rst res", int'(res), 0);
        checkOutput("rst fail", int'(fail), 0);
        checkOutput("rst err_cnt", int'(err), 0);
        checkOutput("rst first_idx", int'(fi), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst done", int'(done), 0);
        applyStimulus(0, 0, 1, 8'h00, 8'hFF, 8'h00);
        checkOutput("idle valid res", int'(res), 0);
        checkOutput("idle valid err_cnt", int'(err), 0);
        checkOutput("idle valid busy", int'(busy), 0);

        // Flipped bit 0 on every pattern with the mask covering that bit
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        for (int p = 0; p < 8; p++) applyStimulus(0, 0, 1, 8'h00, 8'h01, 8'h01);
        checkOutput("mask done", int'(done), 1);
`ifdef RESP_CMP_MASK_EN
        checkOutput("mask fail", int'(fail), 0);
        checkOutput("mask err_cnt", int'(err), 0);
`else
        checkOutput("mask fail", int'(fail), 1);
        checkOutput("mask err_cnt", int'(err), 8);
`endif
        checkModel("mask");

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            r    = ($urandom_range(0, 63) == 0);
            s    = ($urandom_range(0, 7) == 0);
            v    = ($urandom_range(0, 3) != 0);
            a    = 8'($urandom);
            flip = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            b    = a ^ flip;
            m    = 8'($urandom & $urandom & $urandom);
            applyStimulus(r, s, v, a, b, m);
            checkModel($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
